mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NCPU, default 2, meaning the number of CPUs, each with one icache and one dcache port.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port nRST, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports iREN[NCPU], dREN[NCPU], dWEN[NCPU], inputs, 1 each, per-CPU cache memory requests.
REQ-005 SHALL have ports iaddr[NCPU], daddr[NCPU], dstore[NCPU], inputs, 32 each, per-CPU request address and write data.
REQ-006 SHALL have ports iwait[NCPU], dwait[NCPU], outputs, 1 each; 0 means the request completes in this cycle.
REQ-007 SHALL have ports iload[NCPU], dload[NCPU], outputs, 32 each, read data returned to the caches.
REQ-008 SHALL have ports ramREN, ramWEN (outputs, 1), ramaddr, ramstore (outputs, 32), ramload (input, 32), ramstate (input, 2: FREE, BUSY, ACCESS, ERROR).

Function
REQ-009 SHALL implement FSM states IDLE and GRANT; one RAM transaction is outstanding at a time.
REQ-010 In IDLE with any request active, SHALL latch winner CPU index and type (I or D) and enter GRANT on the next edge; in IDLE, ram outputs are 0.
REQ-011 Type priority: any dREN/dWEN SHALL beat any iREN; within a type, CPU selection per REQ-022/REQ-023.
REQ-012 In GRANT, SHALL drive ramaddr/ramstore/ramREN/ramWEN from the latched requester's live inputs.
REQ-013 In GRANT, when ramstate==ACCESS, SHALL drive the granted wait low combinationally in that cycle, drive its load from ramload, and return to IDLE on the next edge.
REQ-014 All non-granted waits SHALL be 1 whenever their request is active; waits of idle requesters are 1.
REQ-015 ramstate BUSY or ERROR in GRANT SHALL hold GRANT with outputs unchanged (ERROR is retried, not reported).
REQ-016 If the granted requester drops its request while in GRANT before ACCESS, SHALL return to IDLE next edge without lowering any wait.
REQ-017 dREN and dWEN both high on one CPU SHALL be treated as a write (ramWEN=1, ramREN=0).
REQ-018 iload/dload of non-granted ports SHALL carry ramload; only the matching wait qualifies them.
REQ-019 Minimum latency: request at cycle 0, GRANT at cycle 1, completion at cycle 1 if ramstate==ACCESS.

Reset
REQ-020 nRST low SHALL asynchronously force IDLE, winner index 0, RR pointer 0, ramREN=ramWEN=0, ramaddr=ramstore=0, all waits 1.
REQ-021 Reset asserted mid-GRANT SHALL abandon the transaction; no wait is lowered for it after reset release.

Configuration
REQ-022 With MEM_ARBITER_RR_EN defined: round-robin among CPUs within a type; pointer advances to (winner+1) mod NCPU only on completion (REQ-013), not on abort.
REQ-023 Without MEM_ARBITER_RR_EN: fixed priority, lowest CPU index wins; no pointer register exists.

Structure
REQ-024 Package mem_arbiter_pkg SHALL hold ramstate_t enum, word_t (32-bit), arb_state_t (IDLE, GRANT), req_type_t (IREQ, DREQ).
REQ-025 Sub-module rr_pick (NCPU-bit request vector, pointer -> one-hot grant plus index) is SHALL-instantiated once per type when MEM_ARBITER_RR_EN is defined.

Verification
REQ-026 CPU0 iREN, iaddr=0x100, ramstate ACCESS in GRANT, ramload=0xDEADBEEF -> iwait[0]=0 for one cycle at cycle 1, iload[0]=0xDEADBEEF, ramREN=1, ramaddr=0x100.
REQ-027 CPU0 iREN and CPU0 dWEN daddr=0x200 dstore=0x5 same cycle -> dcache served first (ramWEN=1, ramstore=0x5), icache granted next IDLE->GRANT.
REQ-028 RR_EN, CPU0 and CPU1 dREN held continuously, ACCESS every GRANT -> completions alternate CPU0, CPU1, CPU0; without RR_EN CPU0 only.
REQ-029 Granted request, ramstate BUSY 3 cycles then ACCESS -> wait stays 1 for 3 cycles, low on 4th; ERROR for 2 cycles then ACCESS -> same retry behaviour.
REQ-030 Granted dREN dropped while BUSY -> return to IDLE, dwait never low, RR pointer unchanged.
REQ-031 nRST pulsed low mid-GRANT -> ramREN/ramWEN 0 immediately without clock edge, all waits 1, FSM in IDLE after release.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: RAM handshake state, data word,
// arbiter FSM state and request type.
package mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef enum logic {
    IREQ = 1'b0,
    DREQ = 1'b1
  } req_type_t;

  // Index width that stays legal for a single-CPU build
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin picker: first active request at or after ptr, wrapping.
// Produces a one-hot grant and the matching index.
module rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  always_comb begin
    grant = '0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned c;
      c = 32'(ptr) + i;
      if (c >= N) c = c - N;
      if ((grant == '0) && req[c]) begin
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-CPU icache/dcache to single-RAM arbiter, one transaction at a time.
// Define MEM_ARBITER_RR_EN for round-robin CPU selection; default is fixed priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NCPU = 2
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [NCPU-1:0] iREN,
  input  logic [NCPU-1:0] dREN,
  input  logic [NCPU-1:0] dWEN,
  input  word_t           iaddr  [NCPU],
  input  word_t           daddr  [NCPU],
  input  word_t           dstore [NCPU],
  output logic [NCPU-1:0] iwait,
  output logic [NCPU-1:0] dwait,
  output word_t           iload  [NCPU],
  output word_t           dload  [NCPU],
  output logic            ramREN,
  output logic            ramWEN,
  output word_t           ramaddr,
  output word_t           ramstore,
  input  word_t           ramload,
  input  ramstate_t       ramstate
);

  localparam int unsigned IW = idx_width(NCPU);

  arb_state_t      state_q, state_d;
  req_type_t       type_q, type_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NCPU-1:0] d_req;
  logic [IW-1:0]   d_idx, i_idx;
  logic            d_any, i_any;
  logic            g_active, done;

  assign d_req = dREN | dWEN;

`ifdef MEM_ARBITER_RR_EN
  logic [IW-1:0]   ptr_q;
  logic [NCPU-1:0] d_gnt, i_gnt;

  rr_pick #(.N(NCPU), .IW(IW)) u_pick_d (.req(d_req), .ptr(ptr_q), .grant(d_gnt), .idx(d_idx));
  rr_pick #(.N(NCPU), .IW(IW)) u_pick_i (.req(iREN),  .ptr(ptr_q), .grant(i_gnt), .idx(i_idx));

  assign d_any = |d_gnt;
  assign i_any = |i_gnt;

  // Pointer moves past the winner only on a completed transfer
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      ptr_q <= '0;
    else if (done)
      ptr_q <= (idx_q == IW'(NCPU - 1)) ? '0 : idx_q + IW'(1);
  end
`else
  assign d_any = |d_req;
  assign i_any = |iREN;

  always_comb begin
    d_idx = '0;
    i_idx = '0;
    for (int i = NCPU - 1; i >= 0; i--) begin
      if (d_req[i]) d_idx = IW'(i);
      if (iREN[i])  i_idx = IW'(i);
    end
  end
`endif

  assign g_active = (type_q == DREQ) ? d_req[idx_q] : iREN[idx_q];
  assign done     = (state_q == GRANT) && g_active && (ramstate == ACCESS);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      type_q  <= IREQ;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    idx_d    = idx_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    case (state_q)
      IDLE: begin
        if (d_any) begin
          type_d  = DREQ;
          idx_d   = d_idx;
          state_d = GRANT;
        end else if (i_any) begin
          type_d  = IREQ;
          idx_d   = i_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Live inputs of the latched requester; a write wins over a read
        if (type_q == DREQ) begin
          ramWEN   = dWEN[idx_q];
          ramREN   = dREN[idx_q] & ~dWEN[idx_q];
          ramaddr  = daddr[idx_q];
          ramstore = dstore[idx_q];
        end else begin
          ramREN   = iREN[idx_q];
          ramaddr  = iaddr[idx_q];
        end
        if (!g_active) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          if (type_q == DREQ) dwait[idx_q] = 1'b0;
          else                iwait[idx_q] = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NCPU; i++) begin
      iload[i] = ramload;
      dload[i] = ramload;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (NCPU=2); expectations follow MEM_ARBITER_RR_EN.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        CLK, nRST;
  logic [1:0]  iREN, dREN, dWEN, iwait, dwait;
  logic [31:0] iaddr [2];
  logic [31:0] daddr [2];
  logic [31:0] dstore [2];
  logic [31:0] iload [2];
  logic [31:0] dload [2];
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  ramstate_t   ramstate;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.NCPU(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear();
    iREN = '0; dREN = '0; dWEN = '0;
    ramstate = FREE;
  endtask

  logic [1:0] exp_w [3];
  logic [1:0] w;

  initial begin
    nRST = 1'b0;
    clear();
    for (int i = 0; i < 2; i++) begin
      iaddr[i] = '0; daddr[i] = '0; dstore[i] = '0;
    end
    ramload = 32'h0;
    #12;
    check("rst_ramren",  32'(ramREN), 32'h0);
    check("rst_ramwen",  32'(ramWEN), 32'h0);
    check("rst_ramaddr", ramaddr,     32'h0);
    check("rst_iwait",   32'(iwait),  32'h3);
    check("rst_dwait",   32'(dwait),  32'h3);
    nRST = 1'b1;
    tick();

    // icache read, minimum latency
    iREN[0] = 1'b1; iaddr[0] = 32'h100; ramstate = ACCESS; ramload = 32'hDEADBEEF;
    #1;
    check("i_idle_wait",  32'(iwait),  32'h3);
    check("i_idle_ramren", 32'(ramREN), 32'h0);
    tick();
    check("i_wait",    32'(iwait),  32'h2);
    check("i_load",    iload[0],    32'hDEADBEEF);
    check("i_ramren",  32'(ramREN), 32'h1);
    check("i_ramaddr", ramaddr,     32'h100);
    iREN[0] = 1'b0;
    tick();
    check("i_after_wait", 32'(iwait), 32'h3);

    // dcache write beats icache read
    iREN[0] = 1'b1; iaddr[0] = 32'h300;
    dWEN[0] = 1'b1; daddr[0] = 32'h200; dstore[0] = 32'h5;
    tick();
    check("dw_ramwen",   32'(ramWEN), 32'h1);
    check("dw_ramren",   32'(ramREN), 32'h0);
    check("dw_ramstore", ramstore,    32'h5);
    check("dw_ramaddr",  ramaddr,     32'h200);
    check("dw_dwait",    32'(dwait),  32'h2);
    check("dw_iwait",    32'(iwait),  32'h3);
    dWEN[0] = 1'b0;
    tick();
    check("dw_idle_ramren", 32'(ramREN), 32'h0);
    check("dw_idle_iwait",  32'(iwait),  32'h3);
    tick();
    check("dw_i_ramren",  32'(ramREN), 32'h1);
    check("dw_i_ramaddr", ramaddr,     32'h300);
    check("dw_i_iwait",   32'(iwait),  32'h2);
    clear();
    tick();

    // read+write on CPU1 treated as write
    dREN[1] = 1'b1; dWEN[1] = 1'b1; daddr[1] = 32'h240; dstore[1] = 32'h77; ramstate = ACCESS;
    tick();
    check("rw_ramwen",   32'(ramWEN), 32'h1);
    check("rw_ramren",   32'(ramREN), 32'h0);
    check("rw_ramaddr",  ramaddr,     32'h240);
    check("rw_ramstore", ramstore,    32'h77);
    check("rw_dwait",    32'(dwait),  32'h1);
    check("rw_dload1",   dload[1],    32'hDEADBEEF);
    clear();
    tick();

    // fresh reset, then both CPUs read continuously
    nRST = 1'b0; #2; nRST = 1'b1;
    tick();
    exp_w[0] = 2'b10;
    exp_w[1] = RR ? 2'b01 : 2'b10;
    exp_w[2] = 2'b10;
    dREN = 2'b11; daddr[0] = 32'h500; daddr[1] = 32'h600; ramstate = ACCESS;
    for (int k = 0; k < 3; k++) begin
      tick();
      w = exp_w[k];
      check($sformatf("seq%0d_dwait", k), 32'(dwait), 32'(w));
      check($sformatf("seq%0d_ramaddr", k), ramaddr, (w == 2'b10) ? 32'h500 : 32'h600);
      tick();
      check($sformatf("seq%0d_idle", k), 32'(dwait), 32'h3);
    end
    clear();
    tick();

    // BUSY then ERROR retries on CPU0
    dREN[0] = 1'b1; ramstate = BUSY;
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("busy%0d_dwait", k), 32'(dwait), 32'h3);
      check($sformatf("busy%0d_ramren", k), 32'(ramREN), 32'h1);
      tick();
    end
    ramstate = ACCESS;
    #1;
    check("busy_done_dwait", 32'(dwait), 32'h2);
    ramstate = ERROR;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("err%0d_dwait", k), 32'(dwait), 32'h3);
      tick();
    end
    ramstate = ACCESS;
    #1;
    check("err_done_dwait", 32'(dwait), 32'h2);
    clear();
    tick();

    // abort while BUSY leaves pointer untouched
    dREN[1] = 1'b1; ramstate = BUSY;
    tick();
    check("abort_grant_ramren", 32'(ramREN), 32'h1);
    dREN[1] = 1'b0;
    #1;
    check("abort_dwait", 32'(dwait), 32'h3);
    ramstate = ACCESS;
    #1;
    check("abort_access_dwait", 32'(dwait), 32'h3);
    tick();
    check("abort_idle_ramren", 32'(ramREN), 32'h0);
    dREN = 2'b11;
    tick();
    check("abort_ptr_dwait", 32'(dwait), RR ? 32'h1 : 32'h2);
    clear();
    tick();

    // async reset mid-GRANT
    dREN[0] = 1'b1; daddr[0] = 32'h400; ramstate = BUSY;
    tick();
    check("mid_ramren", 32'(ramREN), 32'h1);
    nRST = 1'b0;
    #1;
    check("mid_rst_ramren",  32'(ramREN), 32'h0);
    check("mid_rst_ramwen",  32'(ramWEN), 32'h0);
    check("mid_rst_ramaddr", ramaddr,     32'h0);
    check("mid_rst_dwait",   32'(dwait),  32'h3);
    ramstate = ACCESS;
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    check("post_rst_dwait",  32'(dwait),  32'h3);
    check("post_rst_ramren", 32'(ramREN), 32'h0);
    clear();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
